// File: rtl/uart_rib_master_pkg.sv
// Shared constants, reply codes and FSM state encoding for the UART-to-RIB debug bridge.
package uart_rib_master_pkg;

  localparam logic [3:0] RIB_MASK  = 4'hF;
  localparam logic [7:0] REPLY_OK  = 8'h4B;
  localparam logic [7:0] REPLY_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WDATA    = 3'd2,
    ST_REQ      = 3'd3,
    ST_RSP      = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_GUARD = 3'd6
  } state_e;

  // Reply word for a finished bus access: read data, or the write acknowledge.
  function automatic logic [31:0] reply_word(input logic wrcs, input logic [31:0] rdata);
    return wrcs ? {24'h00_0000, REPLY_OK} : rdata;
  endfunction

endpackage

// File: rtl/uart_rib_master.sv
// Debug bridge: parses W/R byte frames from the USART and runs one RIB master
// access per frame, then streams the reply bytes back out through the USART.
module uart_rib_master
  import uart_rib_master_pkg::*;
#(
  parameter logic [31:0] FRAME_TIMEOUT = 32'd1_000_000,
  parameter logic [7:0]  CMD_WR        = 8'h57,
  parameter logic [7:0]  CMD_RD        = 8'h52
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_rx_vld,
  input  logic [7:0]  i_rx_data,
  input  logic        i_tx_rdy,
  output logic        o_tx_en,
  output logic [7:0]  o_tx_data,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  input  logic [31:0] i_ribm_rdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy,
  output logic        o_busy
);

  state_e      state_r;
  state_e      state_next_s;
  logic [1:0]  cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] reply_r;
  logic [31:0] timeout_r;
  logic [2:0]  reply_left_r;
  logic        wrcs_r;
  logic        guard_r;
  logic        tx_en_r;
  logic [7:0]  tx_data_r;
  logic        req_r;
  logic        rdy_r;
  logic        busy_r;
  logic        cmd_ok_s;
  logic        collecting_s;
  logic        timed_out_s;
  logic        send_s;

  assign cmd_ok_s     = (i_rx_data == CMD_WR) || (i_rx_data == CMD_RD);
  assign collecting_s = (state_r == ST_ADDR) || (state_r == ST_WDATA);
  assign timed_out_s  = (timeout_r >= FRAME_TIMEOUT);
  assign send_s       = (state_r == ST_TX) && i_tx_rdy;

  // Next-state decode; bytes arriving outside IDLE/ADDR/WDATA are ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_rx_vld) begin
          state_next_s = cmd_ok_s ? ST_ADDR : ST_TX;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (i_rx_vld) begin
          if (cnt_r == 2'd3) begin
            state_next_s = wrcs_r ? ST_WDATA : ST_REQ;
          end else begin
            state_next_s = ST_ADDR;
          end
        end else if (timed_out_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (i_rx_vld) begin
          state_next_s = (cnt_r == 2'd3) ? ST_REQ : ST_WDATA;
        end else if (timed_out_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WDATA;
        end
      end
      ST_REQ: begin
        if (i_ribm_gnt) begin
          state_next_s = ST_RSP;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (i_ribm_rsp) begin
          state_next_s = ST_TX;
        end else begin
          state_next_s = ST_RSP;
        end
      end
      ST_TX: begin
        if (i_tx_rdy) begin
          state_next_s = ST_TX_GUARD;
        end else begin
          state_next_s = ST_TX;
        end
      end
      ST_TX_GUARD: begin
        if (guard_r) begin
          state_next_s = (reply_left_r != 3'd0) ? ST_TX : ST_IDLE;
        end else begin
          state_next_s = ST_TX_GUARD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame field collection, little-endian, with a 2-bit byte counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_r   <= 2'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wrcs_r  <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      cnt_r <= 2'd0;
      if (i_rx_vld) begin
        wrcs_r <= (i_rx_data == CMD_WR);
      end
    end else if (collecting_s && i_rx_vld) begin
      cnt_r <= cnt_r + 2'd1;
      if (state_r == ST_ADDR) begin
        addr_r[{cnt_r, 3'b000} +: 8] <= i_rx_data;
      end else begin
        wdata_r[{cnt_r, 3'b000} +: 8] <= i_rx_data;
      end
    end
  end

  // Inter-byte idle counter; saturates so a stalled host cannot wrap it
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      timeout_r <= 32'd0;
    end else if (i_rx_vld || !collecting_s) begin
      timeout_r <= 32'd0;
    end else if (!timed_out_s) begin
      timeout_r <= timeout_r + 32'd1;
    end
  end

  // Reply buffer: shifted out LSB first, one byte per TX visit
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      reply_r      <= 32'd0;
      reply_left_r <= 3'd0;
      guard_r      <= 1'b0;
    end else begin
      guard_r <= (state_r == ST_TX_GUARD) ? ~guard_r : 1'b0;
      if ((state_r == ST_IDLE) && i_rx_vld && !cmd_ok_s) begin
        reply_r      <= {24'h00_0000, REPLY_ERR};
        reply_left_r <= 3'd1;
      end else if ((state_r == ST_RSP) && i_ribm_rsp) begin
        reply_r      <= reply_word(wrcs_r, i_ribm_rdata);
        reply_left_r <= wrcs_r ? 3'd1 : 3'd4;
      end else if (send_s) begin
        reply_r      <= reply_r >> 8;
        reply_left_r <= reply_left_r - 3'd1;
      end
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'd0;
      req_r     <= 1'b0;
      rdy_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      tx_en_r <= send_s;
      if (send_s) begin
        tx_data_r <= reply_r[7:0];
      end
      req_r  <= (state_next_s == ST_REQ);
      rdy_r  <= (state_next_s == ST_REQ) || (state_next_s == ST_RSP);
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign o_tx_en      = tx_en_r;
  assign o_tx_data    = tx_data_r;
  assign o_ribm_addr  = addr_r;
  assign o_ribm_wrcs  = wrcs_r;
  assign o_ribm_mask  = RIB_MASK;
  assign o_ribm_wdata = wdata_r;
  assign o_ribm_req   = req_r;
  assign o_ribm_rdy   = rdy_r;
  assign o_busy       = busy_r;

endmodule

// File: tb/tb_uart_rib_master.sv
// Self-checking bench for uart_rib_master: directed frame table plus randomized frames vs. a reference model.
module tb_uart_rib_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_rdy = 1'b1;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [31:0] addr;
  logic        wrcs;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [31:0] rdata = 32'd0;
  logic        req;
  logic        gnt = 1'b0;
  logic        rsp = 1'b0;
  logic        rdy;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rib_master #(.FRAME_TIMEOUT(32'd50)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_vld(rx_vld), .i_rx_data(rx_data),
    .i_tx_rdy(tx_rdy), .o_tx_en(tx_en), .o_tx_data(tx_data),
    .o_ribm_addr(addr), .o_ribm_wrcs(wrcs), .o_ribm_mask(mask), .o_ribm_wdata(wdata),
    .i_ribm_rdata(rdata), .o_ribm_req(req), .i_ribm_gnt(gnt), .i_ribm_rsp(rsp),
    .o_ribm_rdy(rdy), .o_busy(busy)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rsp_dly;
    bit          spur_rsp;
    bit          drop;
    bit          exp_req;
    logic [31:0] exp_reply;
    int          exp_len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: command byte alone decides whether a bus access happens and what comes back.
  task automatic ref_model(input logic [7:0] cmd, input logic [31:0] rd,
                           output bit exp_req, output logic [31:0] rep, output int len);
    if (cmd == 8'h57) begin
      exp_req = 1'b1; rep = 32'h0000_004B; len = 1;
    end else if (cmd == 8'h52) begin
      exp_req = 1'b1; rep = rd; len = 4;
    end else begin
      exp_req = 1'b0; rep = 32'h0000_0045; len = 1;
    end
  endtask

  // Called and returns at a negedge; one-cycle rx strobe.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(v.cmd);
    if (v.cmd == 8'h57 || v.cmd == 8'h52) begin
      for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
    end
    if (v.cmd == 8'h57) begin
      for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
    end
  endtask

  task automatic collect(input string tag, input logic [31:0] rep, input int len);
    int got = 0;
    bit prev = tx_rdy;
    bit saw_req = 1'b0;
    for (int c = 0; c < 300 && got < len; c++) begin
      @(negedge clk);
      if (req) saw_req = 1'b1;
      if (tx_en) begin
        chk({tag, "_tx_gated"}, prev, 1'b1);
        if (got < len) chk({tag, "_tx_byte"}, tx_data, rep[8*got +: 8]);
        got++;
      end
      tx_rdy = ($urandom_range(0, 3) != 0);
      prev = tx_rdy;
    end
    tx_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx_en) got++;
    end
    chk({tag, "_tx_count"}, got, len);
    chk({tag, "_idle_after"}, busy, 1'b0);
    chk({tag, "_no_req_in_tx"}, saw_req, 1'b0);
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    send_frame(v);
    if (v.exp_req) begin
      chk({tag, "_req_latency"}, req, 1'b1);
      chk({tag, "_rdy_req"}, rdy, 1'b1);
      chk({tag, "_addr"}, addr, v.addr);
      chk({tag, "_wrcs"}, wrcs, (v.cmd == 8'h57));
      chk({tag, "_mask"}, mask, 4'hF);
      if (v.cmd == 8'h57) chk({tag, "_wdata"}, wdata, v.wdata);
      for (int i = 0; i < v.gnt_dly; i++) begin
        @(negedge clk);
        chk({tag, "_req_held"}, req, 1'b1);
        chk({tag, "_addr_held"}, addr, v.addr);
      end
      gnt = 1'b1;
      if (v.spur_rsp) begin
        rsp = 1'b1;
        rdata = ~v.rdata;
      end
      @(negedge clk);
      gnt = 1'b0;
      rsp = 1'b0;
      chk({tag, "_req_drop"}, req, 1'b0);
      chk({tag, "_rdy_rsp"}, rdy, 1'b1);
      if (v.drop) begin
        rx_data = 8'h52;
        rx_vld  = 1'b1;
      end
      repeat (v.rsp_dly) begin
        @(negedge clk);
        rx_vld = 1'b0;
      end
      rsp = 1'b1;
      rdata = v.rdata;
      @(negedge clk);
      rsp = 1'b0;
      rdata = 32'd0;
    end
    collect(tag, v.exp_reply, v.exp_len);
  endtask

  vec_t tbl[6];
  vec_t rv;
  bit   saw;

  initial begin
    tbl[0] = '{8'h57, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0,         0, 1, 1'b0, 1'b0, 1'b1, 32'h4B,        1};
    tbl[1] = '{8'h52, 32'h2000_0008, 32'h0,         32'h1234_5678, 3, 1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4};
    tbl[2] = '{8'h41, 32'h0,         32'h0,         32'h0,         0, 1, 1'b0, 1'b0, 1'b0, 32'h45,        1};
    tbl[3] = '{8'h52, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1, 2, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 4};
    tbl[4] = '{8'h52, 32'h0000_0004, 32'h0,         32'hA5A5_5A5A, 0, 1, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A, 4};
    tbl[5] = '{8'hFF, 32'h0,         32'h0,         32'h0,         0, 1, 1'b0, 1'b0, 1'b0, 32'h45,        1};

    repeat (3) @(negedge clk);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req", req, 1'b0);
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_wrcs", wrcs, 1'b0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

    // Partial frame abandoned by the host must be discarded silently.
    send_byte(8'h57);
    send_byte(8'h10);
    saw = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (req || tx_en) saw = 1'b1;
    end
    chk("timeout_still_busy", busy, 1'b1);
    repeat (15) begin
      @(negedge clk);
      if (req || tx_en) saw = 1'b1;
    end
    chk("timeout_quiet", saw, 1'b0);
    chk("timeout_idle", busy, 1'b0);
    do_txn("after_timeout", tbl[1]);

    // Reset while a request is outstanding.
    send_frame(tbl[0]);
    chk("rst_mid_req_up", req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_req", req, 1'b0);
    chk("rst_mid_rdy", rdy, 1'b0);
    chk("rst_mid_tx_en", tx_en, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_txn("after_reset", tbl[0]);

    for (int n = 0; n < 24; n++) begin
      int r = $urandom_range(0, 4);
      if (r < 2) rv.cmd = 8'h57;
      else if (r < 4) rv.cmd = 8'h52;
      else begin
        rv.cmd = 8'($urandom_range(0, 255));
        if (rv.cmd == 8'h57 || rv.cmd == 8'h52) rv.cmd = 8'h00;
      end
      rv.addr     = $urandom;
      rv.wdata    = $urandom;
      rv.rdata    = $urandom;
      rv.gnt_dly  = $urandom_range(0, 3);
      rv.rsp_dly  = $urandom_range(1, 3);
      rv.spur_rsp = 1'($urandom_range(0, 1));
      rv.drop     = 1'($urandom_range(0, 1));
      ref_model(rv.cmd, rv.rdata, rv.exp_req, rv.exp_reply, rv.exp_len);
      do_txn($sformatf("rnd%0d", n), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
